// File: rtl/micro_sequencer.sv
// micro_sequencer: control-store address sequencer with a memory-ready stall.
// Optional single-step gating is enabled by defining MICRO_SEQUENCER_STEP_EN.
module micro_sequencer #(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_IR          = 32
) (
  input  logic                             MICRO_SEQUENCER_CLOCK_50,
  input  logic                             MICRO_SEQUENCER_ResetInLow_In,
  input  logic [DATAWIDTH_CONDITION-1:0]   MICRO_SEQUENCER_Condition_InBus,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_JumpAddress_InBus,
  input  logic                             MICRO_SEQUENCER_RD_In,
  input  logic                             MICRO_SEQUENCER_WR_In,
  input  logic                             MICRO_SEQUENCER_MemReady_In,
  input  logic [3:0]                       MICRO_SEQUENCER_Flags_InBus,
  input  logic [DATAWIDTH_IR-1:0]          MICRO_SEQUENCER_IR_InBus,
`ifdef MICRO_SEQUENCER_STEP_EN
  input  logic                             MICRO_SEQUENCER_Step_In,
`endif
  output logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_Address_OutBus,
  output logic                             MICRO_SEQUENCER_Stall_Out,
  output logic                             MICRO_SEQUENCER_Taken_Out
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [DATAWIDTH_JUMPADDRESS-1:0] ONE = 1;

  logic [0:0] state;
  logic [0:0] stateNext;
  logic       memAccess;
  logic       stepEn;
  logic       advance;
  logic       takeJump;
  logic [DATAWIDTH_JUMPADDRESS-1:0] csaiAddr;
  logic [DATAWIDTH_JUMPADDRESS-1:0] decodeAddr;
  logic [DATAWIDTH_JUMPADDRESS-1:0] nextAddr;
  logic       unusedIrBits;

`ifdef MICRO_SEQUENCER_STEP_EN
  assign stepEn = MICRO_SEQUENCER_Step_In;
`else
  assign stepEn = 1'b1;
`endif

  // RD and WR together still form one access.
  assign memAccess  = MICRO_SEQUENCER_RD_In | MICRO_SEQUENCER_WR_In;
  assign csaiAddr   = MICRO_SEQUENCER_Address_OutBus + ONE;
  assign decodeAddr = {1'b1, MICRO_SEQUENCER_IR_InBus[31:30],
                       MICRO_SEQUENCER_IR_InBus[24:19], 2'b00};
  assign unusedIrBits = ^{MICRO_SEQUENCER_IR_InBus[29:25],
                          MICRO_SEQUENCER_IR_InBus[18:14],
                          MICRO_SEQUENCER_IR_InBus[12:0]};

  always_comb begin
    takeJump = 1'b0;
    nextAddr = csaiAddr;
    case (MICRO_SEQUENCER_Condition_InBus)
      3'd1:    takeJump = MICRO_SEQUENCER_Flags_InBus[3];
      3'd2:    takeJump = MICRO_SEQUENCER_Flags_InBus[2];
      3'd3:    takeJump = MICRO_SEQUENCER_Flags_InBus[1];
      3'd4:    takeJump = MICRO_SEQUENCER_Flags_InBus[0];
      3'd5:    takeJump = MICRO_SEQUENCER_IR_InBus[13];
      3'd6:    takeJump = 1'b1;
      3'd7:    takeJump = 1'b1;
      default: takeJump = 1'b0;
    endcase
    if (MICRO_SEQUENCER_Condition_InBus == 3'd7) begin
      nextAddr = decodeAddr;
    end else if (takeJump) begin
      nextAddr = MICRO_SEQUENCER_JumpAddress_InBus;
    end
  end

  // A pending step keeps WAIT even after memory is ready, so the access is not re-issued.
  always_comb begin
    stateNext = state;
    advance   = 1'b0;
    case (state)
      RUN: begin
        advance = stepEn & (~memAccess | MICRO_SEQUENCER_MemReady_In);
        if (memAccess & ~MICRO_SEQUENCER_MemReady_In) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        advance = stepEn & MICRO_SEQUENCER_MemReady_In;
        if (MICRO_SEQUENCER_MemReady_In & stepEn) begin
          stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  assign MICRO_SEQUENCER_Stall_Out = MICRO_SEQUENCER_ResetInLow_In &
      (((state == RUN) & memAccess & ~MICRO_SEQUENCER_MemReady_In) |
       ((state == WAIT) & ~MICRO_SEQUENCER_MemReady_In));

  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50 or negedge MICRO_SEQUENCER_ResetInLow_In) begin
    if (!MICRO_SEQUENCER_ResetInLow_In) begin
      state                          <= RUN;
      MICRO_SEQUENCER_Address_OutBus <= '0;
      MICRO_SEQUENCER_Taken_Out      <= 1'b0;
    end else begin
      state <= stateNext;
      if (advance) begin
        MICRO_SEQUENCER_Address_OutBus <= nextAddr;
        MICRO_SEQUENCER_Taken_Out      <= takeJump;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: scoreboard bench for micro_sequencer (next-address select,
// memory stall, async reset, wrap). Step gating is covered when MICRO_SEQUENCER_STEP_EN is set.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  cond;
  logic [10:0] jAddr;
  logic        rd, wr, ready;
  logic [3:0]  flags;
  logic [31:0] ir;
  logic        stepV;
  logic [10:0] addr;
  logic        stall, taken;

  logic [10:0] expAddrQ[$];
  logic        expTakenQ[$];
  logic [10:0] mAddr;
  logic        mTaken, mWait;
  logic        expStall, seenStall;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  micro_sequencer dut (
    .MICRO_SEQUENCER_CLOCK_50          (clk),
    .MICRO_SEQUENCER_ResetInLow_In     (rstN),
    .MICRO_SEQUENCER_Condition_InBus   (cond),
    .MICRO_SEQUENCER_JumpAddress_InBus (jAddr),
    .MICRO_SEQUENCER_RD_In             (rd),
    .MICRO_SEQUENCER_WR_In             (wr),
    .MICRO_SEQUENCER_MemReady_In       (ready),
    .MICRO_SEQUENCER_Flags_InBus       (flags),
    .MICRO_SEQUENCER_IR_InBus          (ir),
`ifdef MICRO_SEQUENCER_STEP_EN
    .MICRO_SEQUENCER_Step_In           (stepV),
`endif
    .MICRO_SEQUENCER_Address_OutBus    (addr),
    .MICRO_SEQUENCER_Stall_Out         (stall),
    .MICRO_SEQUENCER_Taken_Out         (taken)
  );

  // Drives one microword, predicts the post-edge address/taken, then clocks it in.
  task automatic applyStimulus(input logic [2:0] c, input logic [10:0] j, input logic r,
                               input logic w, input logic rdy, input logic [3:0] f,
                               input logic [31:0] i);
    logic [10:0] nxt;
    logic tk;
    cond = c; jAddr = j; rd = r; wr = w; ready = rdy; flags = f; ir = i;
    #1;
    expStall  = mWait ? !rdy : ((r | w) & !rdy);
    seenStall = stall;
    case (c)
      3'd1: tk = f[3];
      3'd2: tk = f[2];
      3'd3: tk = f[1];
      3'd4: tk = f[0];
      3'd5: tk = i[13];
      3'd6, 3'd7: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    if (c == 3'd7) nxt = {1'b1, i[31:30], i[24:19], 2'b00};
    else if (tk)   nxt = j;
    else           nxt = mAddr + 11'd1;
    if (!expStall && stepV) begin
      mAddr  = nxt;
      mTaken = tk;
    end
    mWait = expStall | (mWait & !stepV);
    expAddrQ.push_back(mAddr);
    expTakenQ.push_back(mTaken);
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mAddr = 11'h000; mTaken = 1'b0; mWait = 1'b0;
    expAddrQ.delete(); expTakenQ.delete();
  endtask

  task automatic test_reset();
    rstN = 1'b0; stepV = 1'b1;
    cond = 3'd0; jAddr = 11'h0; rd = 1'b1; wr = 1'b0; ready = 1'b0; flags = 4'h0; ir = 32'h0;
    modelReset();
    for (int k = 0; k < 2; k++) begin
      #3;
      checks++; if (addr !== 11'h000) begin errors++; $display("[TB] FAIL reset_addr got %h want 000", addr); end
      checks++; if (taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken got %b want 0", taken); end
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
      @(posedge clk);
    end
    #1;
    rd = 1'b0;
    rstN = 1'b1;
  endtask

  task automatic test_increment();
    logic [10:0] ea; logic et;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(3'd0, 11'h7AA, 1'b0, 1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF);
      ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
      checks++; if (addr !== ea) begin errors++; $display("[TB] FAIL inc_addr got %h want %h", addr, ea); end
      checks++; if (addr !== 11'(k + 1)) begin errors++; $display("[TB] FAIL inc_seq got %h want %h", addr, 11'(k + 1)); end
      checks++; if (taken !== et) begin errors++; $display("[TB] FAIL inc_taken got %b want %b", taken, et); end
    end
  endtask

  task automatic test_jump();
    logic [10:0] ea; logic et;
    applyStimulus(3'd6, 11'h123, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== 11'h123 || ea !== 11'h123) begin errors++; $display("[TB] FAIL jump_addr got %h want 123", addr); end
    checks++; if (taken !== 1'b1 || et !== 1'b1) begin errors++; $display("[TB] FAIL jump_taken got %b want 1", taken); end
    applyStimulus(3'd0, 11'h123, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== ea) begin errors++; $display("[TB] FAIL jump_next got %h want %h", addr, ea); end
    checks++; if (taken !== et) begin errors++; $display("[TB] FAIL jump_taken_drop got %b want %b", taken, et); end
  endtask

  task automatic test_conditions();
    logic [10:0] ea; logic et;
    logic [2:0]  cTab[9] = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5};
    logic [3:0]  fTab[9] = '{4'b0100, 4'b0000, 4'b1000, 4'b0111, 4'b0010, 4'b0001, 4'b1110, 4'b0000, 4'b1111};
    logic [31:0] iTab[9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_2000, 32'hFFFF_DFFF};
    for (int k = 0; k < 9; k++) begin
      applyStimulus(cTab[k], 11'h050 + 11'(k * 16), 1'b0, 1'b0, 1'b0, fTab[k], iTab[k]);
      ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
      checks++; if (addr !== ea) begin errors++; $display("[TB] FAIL cond%0d_addr got %h want %h", k, addr, ea); end
      checks++; if (taken !== et) begin errors++; $display("[TB] FAIL cond%0d_taken got %b want %b", k, taken, et); end
    end
  endtask

  task automatic test_decode();
    logic [10:0] ea; logic et;
    applyStimulus(3'd7, 11'h3FF, 1'b0, 1'b0, 1'b0, 4'h0, 32'h8080_0000);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== 11'h640 || ea !== 11'h640) begin errors++; $display("[TB] FAIL decode_addr got %h want 640", addr); end
    checks++; if (taken !== et) begin errors++; $display("[TB] FAIL decode_taken got %b want %b", taken, et); end
    applyStimulus(3'd7, 11'h3FF, 1'b0, 1'b0, 1'b0, 4'h0, 32'h5E5A_A5A5);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== ea) begin errors++; $display("[TB] FAIL decode2_addr got %h want %h", addr, ea); end
  endtask

  task automatic test_mem_wait();
    logic [10:0] ea; logic et;
    logic [2:0] cTab[11] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
    logic       rTab[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       wTab[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       yTab[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 11; k++) begin
      applyStimulus(cTab[k], 11'h300, rTab[k], wTab[k], yTab[k], 4'h0, 32'h0);
      ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
      checks++; if (seenStall !== expStall) begin errors++; $display("[TB] FAIL mem%0d_stall got %b want %b", k, seenStall, expStall); end
      checks++; if (addr !== ea) begin errors++; $display("[TB] FAIL mem%0d_addr got %h want %h", k, addr, ea); end
      checks++; if (taken !== et) begin errors++; $display("[TB] FAIL mem%0d_taken got %b want %b", k, taken, et); end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [10:0] ea; logic et;
    applyStimulus(3'd0, 11'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== ea || taken !== et) begin errors++; $display("[TB] FAIL midwait_hold got %h want %h", addr, ea); end
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL midwait_stall got %b want 1", stall); end
    rstN = 1'b0;
    #1;
    modelReset();
    checks++; if (addr !== 11'h000) begin errors++; $display("[TB] FAIL midwait_addr got %h want 000", addr); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL midwait_stall_rst got %b want 0", stall); end
    @(posedge clk);
    #1;
    rd = 1'b0;
    rstN = 1'b1;
    applyStimulus(3'd0, 11'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== 11'h001 || ea !== 11'h001) begin errors++; $display("[TB] FAIL midwait_resume got %h want 001", addr); end
  endtask

  task automatic test_wrap();
    logic [10:0] ea; logic et;
    applyStimulus(3'd6, 11'h7FF, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== 11'h7FF) begin errors++; $display("[TB] FAIL wrap_pre got %h want 7ff", addr); end
    applyStimulus(3'd0, 11'h7FF, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== 11'h000 || ea !== 11'h000) begin errors++; $display("[TB] FAIL wrap_addr got %h want 000", addr); end
    checks++; if (taken !== 1'b0) begin errors++; $display("[TB] FAIL wrap_taken got %b want 0", taken); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ea; logic et;
    logic r, w;
    for (int k = 0; k < 60; k++) begin
      r = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 4) == 0);
      applyStimulus(3'($urandom_range(0, 7)), 11'($urandom), r, w, 1'($urandom_range(0, 1)),
                    4'($urandom), 32'($urandom));
      ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
      checks++; if (seenStall !== expStall) begin errors++; $display("[TB] FAIL b2b%0d_stall got %b want %b", k, seenStall, expStall); end
      checks++; if (addr !== ea) begin errors++; $display("[TB] FAIL b2b%0d_addr got %h want %h", k, addr, ea); end
      checks++; if (taken !== et) begin errors++; $display("[TB] FAIL b2b%0d_taken got %b want %b", k, taken, et); end
    end
    applyStimulus(3'd0, 11'h0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== ea) begin errors++; $display("[TB] FAIL b2b_drain got %h want %h", addr, ea); end
  endtask

`ifdef MICRO_SEQUENCER_STEP_EN
  task automatic test_step_hold();
    logic [10:0] ea; logic et;
    stepV = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(3'd0, 11'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
      ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
      checks++; if (addr !== ea) begin errors++; $display("[TB] FAIL step%0d_addr got %h want %h", k, addr, ea); end
    end
    stepV = 1'b1;
    applyStimulus(3'd0, 11'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    ea = expAddrQ.pop_front(); et = expTakenQ.pop_front();
    checks++; if (addr !== ea) begin errors++; $display("[TB] FAIL step_resume got %h want %h", addr, ea); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_increment();
    test_jump();
    test_conditions();
    test_decode();
    test_mem_wait();
    test_reset_mid_wait();
    test_wrap();
    test_back_to_back();
`ifdef MICRO_SEQUENCER_STEP_EN
    test_step_hold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
